// File: rtl/dm_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_DONE = 2'd2
    } dbg_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = $clog2(STARVE_MAX_DEF + 1);

    // Counter width for an arbitrary starvation limit (module parameters cannot reach the package).
    function automatic int starve_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating starvation counter: counts CPU grants while a debug read waits.
// Registered count, next-state applied on posedge; clear has priority over increment.
module dm_arb_starve_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic         at_max_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_o = (cnt_q == max_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Cycle-by-cycle arbiter sharing the DM port between the MEM stage (zero latency) and a debug reader.
// CPU is stalled only in cycles the debug read wins; debug waits at most STARVE_MAX+1 cycles.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DBG_ADDR_W = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic [DBG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_ack,
    output logic [ADDR_W-1:0]     dm_addr,
    output logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_re,
    output logic                  dm_we,
    input  logic [DATA_W-1:0]     dm_rdata
);

    localparam int               CNT_W   = starve_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    dbg_state_t        state_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              dbg_ack_q;

    logic              in_wait;
    logic              starve_hit;
    logic              dbg_win;
    logic              cpu_win;
    logic [ADDR_W-1:0] dbg_byte_addr;

    assign in_wait       = (state_q == D_WAIT);
    assign dbg_win       = in_wait & dbg_req & (~cpu_req | starve_hit);
    assign cpu_win       = cpu_req & ~dbg_win;
    assign dbg_byte_addr = {{(ADDR_W-DBG_ADDR_W-2){1'b0}}, dbg_addr, 2'b00};

    dm_arb_starve_cnt #(
        .W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (cpu_win & in_wait),
        .clr_i    (dbg_win | ~in_wait),
        .max_i    (CNT_MAX),
        .at_max_o (starve_hit)
    );

    // Outputs are forced quiet during reset so a store in flight is dropped at once.
    always_comb begin
        dm_addr  = cpu_addr;
        dm_wdata = cpu_wdata;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        if (!rst) begin
            if (dbg_win) begin
                dm_addr = dbg_byte_addr;
                dm_re   = 1'b1;
            end else if (cpu_win) begin
                dm_re = ~cpu_we;
                dm_we = cpu_we;
            end
        end
    end

    assign cpu_rdata = dm_rdata;
    assign cpu_ack   = ~rst & cpu_win;
    assign cpu_stall = ~rst & cpu_req & dbg_win;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= D_IDLE;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                D_IDLE: begin
                    if (dbg_req) begin
                        state_q <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (!dbg_req) begin
                        state_q <= D_IDLE;
                    end else if (dbg_win) begin
                        dbg_rdata_q <= dm_rdata;
                        dbg_ack_q   <= 1'b1;
                        state_q     <= D_DONE;
                    end
                end
                D_DONE: begin
                    state_q <= D_IDLE;
                end
                default: begin
                    state_q <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: two instances (STARVE_MAX 4 and 1) share stimulus, each with its own DM and reference model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dbg_req;
    logic [9:0]  dbg_addr;

    logic [31:0] cpu_rdata_w [2];
    logic [31:0] dbg_rdata_w [2];
    logic [31:0] dm_addr_w   [2];
    logic [31:0] dm_wdata_w  [2];
    logic [31:0] dm_rdata_w  [2];
    logic        cpu_ack_w   [2];
    logic        cpu_stall_w [2];
    logic        dbg_ack_w   [2];
    logic        dm_re_w     [2];
    logic        dm_we_w     [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bit [31:0] mem [1024];

        assign dm_rdata_w[g] = mem[dm_addr_w[g][11:2]];

        always @(posedge clk) begin
            if (dm_we_w[g]) mem[dm_addr_w[g][11:2]] <= dm_wdata_w[g];
        end

        dm_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .DBG_ADDR_W (10),
            .STARVE_MAX ((g == 0) ? 4 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cpu_req   (cpu_req),
            .cpu_we    (cpu_we),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_rdata (cpu_rdata_w[g]),
            .cpu_ack   (cpu_ack_w[g]),
            .cpu_stall (cpu_stall_w[g]),
            .dbg_req   (dbg_req),
            .dbg_addr  (dbg_addr),
            .dbg_rdata (dbg_rdata_w[g]),
            .dbg_ack   (dbg_ack_w[g]),
            .dm_addr   (dm_addr_w[g]),
            .dm_wdata  (dm_wdata_w[g]),
            .dm_re     (dm_re_w[g]),
            .dm_we     (dm_we_w[g]),
            .dm_rdata  (dm_rdata_w[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[sm=%0d] @%0t: got %0h expected %0h", tag, (k == 0) ? 4 : 1, $time, got, exp);
        end
    endtask

    function automatic int smx(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference model: a pending debug request, a pulse owed next cycle, and the CPU wins seen while pending.
    bit          m_pending [2];
    bit          m_ack     [2];
    int          m_streak  [2];
    logic [31:0] m_rd      [2];
    bit   [31:0] gmem      [2][1024];
    bit          e_dw      [2];
    bit          e_cw      [2];

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_dw[k] = 1'b0;
                e_cw[k] = 1'b0;
                chk("rst_dm_we",     k, dm_we_w[k],     0);
                chk("rst_dm_re",     k, dm_re_w[k],     0);
                chk("rst_cpu_ack",   k, cpu_ack_w[k],   0);
                chk("rst_cpu_stall", k, cpu_stall_w[k], 0);
                chk("rst_dbg_ack",   k, dbg_ack_w[k],   0);
                chk("rst_dbg_rdata", k, dbg_rdata_w[k], 0);
            end else begin
                e_dw[k] = m_pending[k] && dbg_req && (!cpu_req || m_streak[k] >= smx(k));
                e_cw[k] = cpu_req && !e_dw[k];
                chk("cpu_ack",   k, cpu_ack_w[k],   e_cw[k]);
                chk("cpu_stall", k, cpu_stall_w[k], cpu_req && e_dw[k]);
                chk("dm_re",     k, dm_re_w[k],     e_dw[k] || (e_cw[k] && !cpu_we));
                chk("dm_we",     k, dm_we_w[k],     e_cw[k] && cpu_we);
                chk("dm_addr",   k, dm_addr_w[k],   e_dw[k] ? {20'd0, dbg_addr, 2'b00} : cpu_addr);
                if (!e_dw[k]) chk("dm_wdata", k, dm_wdata_w[k], cpu_wdata);
                if (e_cw[k] && !cpu_we) chk("cpu_rdata", k, cpu_rdata_w[k], gmem[k][cpu_addr[11:2]]);
                chk("dbg_ack",   k, dbg_ack_w[k],   m_ack[k]);
                chk("dbg_rdata", k, dbg_rdata_w[k], m_rd[k]);
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pending[k] = 1'b0;
                m_ack[k]     = 1'b0;
                m_streak[k]  = 0;
                m_rd[k]      = '0;
            end else begin
                if (e_dw[k]) m_rd[k] = gmem[k][dbg_addr];
                if (e_cw[k] && cpu_we) gmem[k][cpu_addr[11:2]] = cpu_wdata;
                if (!m_pending[k] || e_dw[k]) m_streak[k] = 0;
                else if (e_cw[k] && m_streak[k] < smx(k)) m_streak[k]++;
                if (m_ack[k]) m_pending[k] = 1'b0;
                else if (m_pending[k]) m_pending[k] = dbg_req && !e_dw[k];
                else m_pending[k] = dbg_req;
                m_ack[k] = e_dw[k];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d,
                         input bit dreq, input logic [9:0] da);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        dbg_req   = dreq;
        dbg_addr  = da;
    endtask

    int stall_at [2];
    bit dreq_r;

    initial begin
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 10'h0);
        tick();
        rst = 1'b0;
        tick();

        // CPU-only store then load
        drive(1, 1, 32'h40, 32'h1234, 0, 10'h0);
        #3;
        for (int k = 0; k < 2; k++) chk("t1_sw_ack", k, cpu_ack_w[k], 1);
        tick();
        drive(1, 0, 32'h40, 32'h0, 0, 10'h0);
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("t1_lw_ack",   k, cpu_ack_w[k],   1);
            chk("t1_lw_data",  k, cpu_rdata_w[k], 32'h1234);
            chk("t1_lw_stall", k, cpu_stall_w[k], 0);
        end
        tick();

        // Debug-only read of word 0x10
        drive(0, 0, 32'h0, 32'h0, 1, 10'h10);
        tick();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("t2_dm_addr", k, dm_addr_w[k], 32'h40);
            chk("t2_dm_re",   k, dm_re_w[k],   1);
        end
        tick();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("t2_ack",   k, dbg_ack_w[k],   1);
            chk("t2_rdata", k, dbg_rdata_w[k], 32'h1234);
        end
        tick();
        drive(0, 0, 32'h0, 32'h0, 0, 10'h0);
        tick();
        tick();

        // Contention with back-to-back stores
        stall_at[0] = -1;
        stall_at[1] = -1;
        drive(1, 1, 32'h48, 32'hA5A5_0001, 1, 10'h12);
        for (int c = 0; c < 12; c++) begin
            #3;
            for (int k = 0; k < 2; k++) begin
                if (cpu_stall_w[k] && stall_at[k] < 0) begin
                    stall_at[k] = c;
                    chk("t3_stall_we", k, dm_we_w[k], 0);
                end
            end
            tick();
            cpu_wdata = cpu_wdata + 32'h1;
        end
        for (int k = 0; k < 2; k++) chk("t3_stall_cycle", k, stall_at[k], smx(k) + 1);
        drive(0, 0, 32'h0, 32'h0, 0, 10'h0);
        tick();
        tick();
        tick();

        // One-cycle debug request under CPU traffic aborts silently
        drive(1, 0, 32'h40, 32'h0, 1, 10'h10);
        tick();
        drive(1, 0, 32'h40, 32'h0, 0, 10'h10);
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("t4_stall", k, cpu_stall_w[k], 0);
            chk("t4_re_cpu", k, dm_addr_w[k], 32'h40);
        end
        tick();
        #3;
        for (int k = 0; k < 2; k++) chk("t4_no_ack", k, dbg_ack_w[k], 0);
        tick();

        // Async reset in the middle of a contended debug wait
        drive(1, 1, 32'h44, 32'hBEEF, 1, 10'h11);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_dm_we",    k, dm_we_w[k],     0);
            chk("t5_cpu_ack",  k, cpu_ack_w[k],   0);
            chk("t5_dbg_ack",  k, dbg_ack_w[k],   0);
            chk("t5_dbg_rdat", k, dbg_rdata_w[k], 0);
        end
        tick();
        rst = 1'b0;
        drive(1, 0, 32'h44, 32'h0, 0, 10'h0);
        #3;
        for (int k = 0; k < 2; k++) chk("t5_first_grant", k, cpu_ack_w[k], 1);
        tick();

        // Randomized traffic with sticky debug requests and rare resets
        dreq_r = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) dreq_r = ~dreq_r;
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  {25'd0, 5'($urandom_range(0, 31)), 2'($urandom)}, $urandom,
                  dreq_r, 10'($urandom_range(0, 31)));
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
